// File: rtl/nibble_pkg.sv
// -----------------------------------------------------------------------------
// nibble_pkg
// Shared definitions for the nibble packer: packer state encoding, nibble
// width, the largest supported word size and the word-counter width.
// No ports (package).
// -----------------------------------------------------------------------------
package nibble_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int MAX_NIBBLES = 4;
    localparam int WORD_CNT_W  = 8;
    // Wide enough to hold a nibble count of 0..MAX_NIBBLES.
    localparam int COUNT_W     = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_packer_if.sv
// -----------------------------------------------------------------------------
// nibble_packer_if
// Bundles the nibble packer's upstream handshake, flush request and downstream
// word handshake.
//   in_valid/in_data/in_ready : upstream nibble handshake
//   flush                     : request early emission of a partial word
//   out_valid/out_data/
//   out_count/out_ready       : downstream packed-word handshake
//   out_parity                : even parity of out_data (0 unless enabled)
//   word_cnt                  : words handed off, modulo 256
// Modports: master = traffic source/sink around the packer, slave = packer.
// -----------------------------------------------------------------------------
interface nibble_packer_if #(
    parameter int WORD_NIBBLES = 4
) ();
    import nibble_pkg::*;

    logic                             in_valid;
    logic [NIBBLE_W-1:0]              in_data;
    logic                             in_ready;
    logic                             flush;
    logic                             out_valid;
    logic [NIBBLE_W*WORD_NIBBLES-1:0] out_data;
    logic [COUNT_W-1:0]               out_count;
    logic                             out_ready;
    logic                             out_parity;
    logic [WORD_CNT_W-1:0]            word_cnt;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_parity, word_cnt
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_count, out_parity, word_cnt
    );

endinterface

// File: rtl/nibble_fill_ctr.sv
// -----------------------------------------------------------------------------
// nibble_fill_ctr
// Counts nibbles collected into the word under construction.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : clear the count (word emitted); wins over i_inc
//   i_inc    : one more nibble collected
//   o_fill   : current number of collected nibbles
//   o_last   : the next collected nibble completes the word
// -----------------------------------------------------------------------------
module nibble_fill_ctr
    import nibble_pkg::*;
#(
    parameter int WORD_NIBBLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_inc,
    output logic [COUNT_W-1:0] o_fill,
    output logic               o_last
);

    logic [COUNT_W-1:0] r_fill;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_fill <= '0;
        end else if (i_inc) begin
            r_fill <= r_fill + COUNT_W'(1);
        end
    end

    assign o_fill = r_fill;
    assign o_last = (r_fill == COUNT_W'(WORD_NIBBLES - 1));

endmodule

// File: rtl/nibble_packer.sv
// -----------------------------------------------------------------------------
// nibble_packer
// Packs 4-bit nibbles LSB-first into words of WORD_NIBBLES nibbles. A word is
// emitted when full or when flush is requested with at least one nibble
// collected; it is held stable until the downstream accepts it.
//   clk, rst : clock, synchronous active-high reset
//   bus      : nibble_packer_if.slave (upstream, flush, downstream, word_cnt)
// Optional feature: define PACK_PARITY_EN to register even parity of out_data
// into out_parity; otherwise out_parity is tied to 0.
// -----------------------------------------------------------------------------
module nibble_packer
    import nibble_pkg::*;
#(
    parameter int WORD_NIBBLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    nibble_packer_if.slave  bus
);

    localparam int WORD_W = NIBBLE_W * WORD_NIBBLES;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [COUNT_W-1:0]    w_fill;
    logic                  w_last;
    logic                  w_hold;
    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic                  w_flush_eff;
    logic                  w_emit;
    logic [COUNT_W-1:0]    w_count_nxt;
    logic [WORD_W-1:0]     w_word;
    logic [WORD_W-1:0]     r_acc;
    logic [WORD_W-1:0]     r_out_data;
    logic [COUNT_W-1:0]    r_out_count;
    logic [WORD_CNT_W-1:0] r_word_cnt;

    assign w_hold       = (r_state == HOLD);
    assign bus.in_ready = !w_hold || bus.out_ready;
    assign w_in_xfer    = bus.in_valid && bus.in_ready;
    assign w_out_xfer   = w_hold && bus.out_ready;

    // A flush while a word is held is dropped, not deferred.
    assign w_flush_eff  = bus.flush && !w_hold;
    assign w_count_nxt  = w_fill + COUNT_W'(w_in_xfer);
    assign w_emit       = (w_in_xfer && w_last) ||
                          (w_flush_eff && ((w_fill != '0) || w_in_xfer));

    nibble_fill_ctr #(
        .WORD_NIBBLES (WORD_NIBBLES)
    ) u_fill_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_emit),
        .i_inc  (w_in_xfer && !w_emit),
        .o_fill (w_fill),
        .o_last (w_last)
    );

    // Word as it stands after this cycle's nibble (if any) is slotted in at
    // the current fill position; r_acc keeps unfilled nibbles at zero.
    always_comb begin
        w_word = r_acc;
        if (w_in_xfer) begin
            for (int k = 0; k < WORD_NIBBLES; k++) begin
                if (w_fill == COUNT_W'(k)) begin
                    w_word[NIBBLE_W*k +: NIBBLE_W] = bus.in_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY, FILL: begin
                if (w_emit) begin
                    w_state_nxt = HOLD;
                end else if (w_count_nxt != '0) begin
                    w_state_nxt = FILL;
                end else begin
                    w_state_nxt = EMPTY;
                end
            end
            HOLD: begin
                // A nibble arriving with the hand-off starts the next word.
                if (!w_out_xfer || w_emit) begin
                    w_state_nxt = HOLD;
                end else if (w_count_nxt != '0) begin
                    w_state_nxt = FILL;
                end else begin
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_word_cnt  <= '0;
        end else begin
            if (w_out_xfer) begin
                r_word_cnt <= r_word_cnt + WORD_CNT_W'(1);
            end
            if (w_emit) begin
                r_out_data  <= w_word;
                r_out_count <= w_count_nxt;
                r_acc       <= '0;
            end else if (w_in_xfer) begin
                r_acc <= w_word;
            end
        end
    end

`ifdef PACK_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_emit) begin
            r_parity <= ^w_word;
        end
    end

    assign bus.out_parity = r_parity;
`else
    assign bus.out_parity = 1'b0;
`endif

    assign bus.out_valid = w_hold;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;
    assign bus.word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_nibble_packer.sv
// -----------------------------------------------------------------------------
// tb_nibble_packer
// Directed and randomised stimulus for nibble_packer (WORD_NIBBLES = 4) with a
// queue-based reference model checked every cycle plus literal expectations.
// -----------------------------------------------------------------------------
module tb_nibble_packer;
    import nibble_pkg::*;

    localparam int WN = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    nibble_packer_if #(.WORD_NIBBLES(WN)) bus ();

    nibble_packer #(
        .WORD_NIBBLES (WN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: nibbles collected in a list, word built from the list.
    logic        m_hold  = 1'b0;
    logic [15:0] m_word  = '0;
    int          m_cnt   = 0;
    logic        m_par   = 1'b0;
    logic [7:0]  m_wc    = '0;
    int          cur[$];
    bit          started = 1'b0;

    always @(posedge clk) begin : model
        logic rdy;
        logic ixf;
        logic oxf;
        logic was_hold;
        if (rst) begin
            m_hold  = 1'b0;
            m_word  = '0;
            m_cnt   = 0;
            m_par   = 1'b0;
            m_wc    = '0;
            cur.delete();
            started = 1'b1;
        end else if (started) begin
            was_hold = m_hold;
            rdy      = !m_hold || bus.out_ready;
            ixf      = bus.in_valid && rdy;
            oxf      = m_hold && bus.out_ready;
            if (oxf) begin
                m_wc   = m_wc + 8'd1;
                m_hold = 1'b0;
            end
            if (ixf) cur.push_back(int'(bus.in_data));
            if (cur.size() == WN || (bus.flush && !was_hold && cur.size() > 0)) begin
                m_word = '0;
                foreach (cur[k]) m_word = m_word | (16'(cur[k]) << (4 * k));
                m_cnt = cur.size();
`ifdef PACK_PARITY_EN
                m_par = ($countones(m_word) % 2) == 1;
`else
                m_par = 1'b0;
`endif
                cur.delete();
                m_hold = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", 32'(bus.in_ready), 32'(!m_hold || bus.out_ready));
            chk("out_valid", 32'(bus.out_valid), 32'(m_hold));
            chk("word_cnt", 32'(bus.word_cnt), 32'(m_wc));
            if (m_hold) begin
                chk("out_data", 32'(bus.out_data), 32'(m_word));
                chk("out_count", 32'(bus.out_count), 32'(m_cnt));
                chk("out_parity", 32'(bus.out_parity), 32'(m_par));
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] d, input logic f, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = f;
        bus.out_ready = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic par1;
`ifdef PACK_PARITY_EN
        par1 = 1'b1;
`else
        par1 = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) drive(1'b0, 4'h0, 1'b0, 1'b1);
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_count", 32'(bus.out_count), 0);
        chk("rst_word_cnt", 32'(bus.word_cnt), 0);

        // Full word 1,2,3,4
        drive(1'b1, 4'h1, 1'b0, 1'b1);
        drive(1'b1, 4'h2, 1'b0, 1'b1);
        drive(1'b1, 4'h3, 1'b0, 1'b1);
        drive(1'b1, 4'h4, 1'b0, 1'b1);
        chk("full_valid", 32'(bus.out_valid), 1);
        chk("full_data", 32'(bus.out_data), 'h4321);
        chk("full_count", 32'(bus.out_count), 4);
        chk("full_wc_before", 32'(bus.word_cnt), 0);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        chk("full_wc_after", 32'(bus.word_cnt), 1);
        chk("full_valid_after", 32'(bus.out_valid), 0);

        // Partial word A,B then flush alone; then flush from empty
        drive(1'b1, 4'hA, 1'b0, 1'b1);
        drive(1'b1, 4'hB, 1'b0, 1'b1);
        drive(1'b0, 4'h0, 1'b1, 1'b1);
        chk("flush_valid", 32'(bus.out_valid), 1);
        chk("flush_data", 32'(bus.out_data), 'h00BA);
        chk("flush_count", 32'(bus.out_count), 2);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        drive(1'b0, 4'h0, 1'b1, 1'b1);
        chk("flush_empty_valid", 32'(bus.out_valid), 0);
        chk("flush_empty_wc", 32'(bus.word_cnt), 2);

        // Back-pressure in HOLD, then hand-off with a new nibble
        drive(1'b1, 4'h9, 1'b0, 1'b0);
        drive(1'b1, 4'hA, 1'b0, 1'b0);
        drive(1'b1, 4'hB, 1'b0, 1'b0);
        drive(1'b1, 4'hC, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'hF, 1'b0, 1'b0);
            chk("stall_in_ready", 32'(bus.in_ready), 0);
            chk("stall_data", 32'(bus.out_data), 'hCBA9);
        end
        drive(1'b1, 4'h7, 1'b0, 1'b1);
        chk("handoff_valid", 32'(bus.out_valid), 0);
        chk("handoff_wc", 32'(bus.word_cnt), 3);
        drive(1'b1, 4'h1, 1'b0, 1'b1);
        drive(1'b1, 4'h2, 1'b0, 1'b1);
        drive(1'b1, 4'h3, 1'b0, 1'b1);
        chk("handoff_data", 32'(bus.out_data), 'h3217);
        chk("handoff_count", 32'(bus.out_count), 4);
        drive(1'b0, 4'h0, 1'b0, 1'b1);

        // Reset mid-word discards everything
        drive(1'b1, 4'h1, 1'b0, 1'b1);
        drive(1'b1, 4'h2, 1'b0, 1'b1);
        drive(1'b1, 4'h3, 1'b0, 1'b1);
        rst = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        rst = 1'b0;
        chk("midrst_valid", 32'(bus.out_valid), 0);
        chk("midrst_data", 32'(bus.out_data), 0);
        chk("midrst_count", 32'(bus.out_count), 0);
        chk("midrst_parity", 32'(bus.out_parity), 0);
        chk("midrst_wc", 32'(bus.word_cnt), 0);
        chk("midrst_in_ready", 32'(bus.in_ready), 1);
        drive(1'b1, 4'h5, 1'b0, 1'b1);
        drive(1'b1, 4'h6, 1'b0, 1'b1);
        drive(1'b1, 4'h7, 1'b0, 1'b1);
        drive(1'b1, 4'h8, 1'b0, 1'b1);
        chk("postrst_data", 32'(bus.out_data), 'h8765);
        drive(1'b0, 4'h0, 1'b0, 1'b1);

        // Parity words 0001 and 0003 (nibble and flush in the same cycle)
        drive(1'b1, 4'h1, 1'b1, 1'b1);
        chk("par1_data", 32'(bus.out_data), 'h0001);
        chk("par1_count", 32'(bus.out_count), 1);
        chk("par1_parity", 32'(bus.out_parity), 32'(par1));
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        drive(1'b1, 4'h3, 1'b1, 1'b1);
        chk("par3_data", 32'(bus.out_data), 'h0003);
        chk("par3_parity", 32'(bus.out_parity), 0);
        drive(1'b0, 4'h0, 1'b0, 1'b1);

        // 256 words: word_cnt wraps to 0
        rst = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        rst = 1'b0;
        for (int w = 0; w < 256; w++) begin
            for (int k = 0; k < WN; k++) drive(1'b1, 4'(w + k), 1'b0, 1'b1);
        end
        chk("wrap_wc_255", 32'(bus.word_cnt), 255);
        chk("wrap_valid", 32'(bus.out_valid), 1);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        chk("wrap_wc_0", 32'(bus.word_cnt), 0);

        // Random valid/ready/flush traffic against the model
        repeat (3000) begin
            drive($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 6);
        end
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        chk("final_valid", 32'(bus.out_valid), 0);
        chk("final_wc", 32'(bus.word_cnt), 32'(m_wc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 Parameter: WORD_NIBBLES, default 4, number of 4-bit nibbles per packed word (legal 2..4).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream nibble present.
REQ-005 in_data  input  4  nibble payload.
REQ-006 in_ready  output  1  packer accepts nibble this cycle.
REQ-007 flush  input  1  request early emission of a partial word.
REQ-008 out_valid  output  1  packed word present.
REQ-009 out_data  output  4*WORD_NIBBLES  packed word.
REQ-010 out_count  output  3  number of valid nibbles in out_data (1..WORD_NIBBLES).
REQ-011 out_ready  input  1  downstream accepts word this cycle.
REQ-012 out_parity  output  1  even parity of out_data (see Configuration).
REQ-013 word_cnt  output  8  count of words handed off, wraps 255->0.

Function
REQ-014 Transfer in: in_valid & in_ready same cycle; transfer out: out_valid & out_ready same cycle.
REQ-015 in_ready SHALL equal !out_valid | out_ready (combinational, no other term).
REQ-016 States: EMPTY (fill=0, out_valid=0), FILL (1<=fill<WORD_NIBBLES, out_valid=0), HOLD (out_valid=1).
REQ-017 Packing LSB-first: k-th accepted nibble of a word (k from 0) lands in out_data[4k+3:4k]; unfilled nibbles are 0.
REQ-018 Nibble accepted completing the word (fill reaches WORD_NIBBLES): next cycle HOLD, out_count=WORD_NIBBLES, fill cleared; latency 1 cycle.
REQ-019 flush while not HOLD with fill>0 or with a nibble accepted same cycle: next cycle HOLD with out_count = fill incl. that nibble.
REQ-020 flush in EMPTY with no nibble accepted: ignored, no word emitted.
REQ-021 flush during HOLD: ignored; not remembered.
REQ-022 HOLD: out_data, out_count, out_parity stable until out transfer.
REQ-023 Out transfer with no in transfer: next state EMPTY, out_valid=0.
REQ-024 Out transfer and in transfer same cycle: nibble becomes nibble 0 of new word, next state FILL (or HOLD if WORD_NIBBLES reached via flush).
REQ-025 word_cnt increments by 1 on every out transfer, modulo 256.
REQ-026 in_data ignored on cycles without in transfer; no nibble lost or duplicated.

Reset
REQ-027 rst=1 at rising edge: state EMPTY, fill=0, out_valid=0, out_data=0, out_count=0, out_parity=0, word_cnt=0.
REQ-028 rst mid-word or in HOLD discards partial/pending word; no out transfer counted that cycle.
REQ-029 in_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-030 Macro PACK_PARITY_EN defined: out_parity = XOR of all out_data bits, registered with out_data.
REQ-031 PACK_PARITY_EN undefined: out_parity tied 0, no parity logic; all other behaviour identical.

Structure
REQ-032 Shared package nibble_pkg holds: state encoding (EMPTY/FILL/HOLD), NIBBLE_W=4, MAX_NIBBLES=4, WORD_CNT_W=8.
REQ-033 One sub-module nibble_fill_ctr: fill counter with clear/increment and terminal-count flag; rest stays in nibble_packer.

Verification
REQ-034 WORD_NIBBLES=4, out_ready=1, feed 1,2,3,4 back-to-back -> one cycle after nibble 4: out_valid=1, out_data=16'h4321, out_count=4, word_cnt 0->1 next cycle.
REQ-035 Feed A,B, then flush alone -> out_data=16'h00BA, out_count=2; flush from EMPTY -> out_valid stays 0.
REQ-036 HOLD with out_ready=0 five cycles -> in_ready=0, out_data stable; then out_ready=1 with in_valid, in_data=7 -> new word nibble 0 = 7, no gap.
REQ-037 rst after 3 nibbles -> all outputs 0; next 4 nibbles 5,6,7,8 -> out_data=16'h8765.
REQ-038 With PACK_PARITY_EN, word 16'h0001 -> out_parity=1, 16'h0003 -> 0; without macro -> always 0.
REQ-039 256 words emitted -> word_cnt wraps to 0; random valid/ready stalls -> scoreboard order and content exact.
